ivs_scan_ctrl: RTL
==================

// Module: ivs_scan_ctrl
// PURPOSE
//  Frame scan sequencer downstream of the IVS AHB slave. Consumes glb_ctrl and
//  cfg_par0/cfg_par1 from the slave. Emits a raster stream of pixel coordinates
//  on a valid/ready handshake toward the pixel datapath. Returns busy/done/error
//  status and a frame count for the slave's status registers.
// PARAMETERS
//  XW      12  width of pix_x and of the configured frame width
//  YW      12  height coordinate width
//  GW      16  line-gap counter width
//  FW      16  frame counter width
// PORTS
//  hclk       in   1   clock
//  hrst       in   1   reset, asynchronous, active-high
//  sw_rst     in   1   synchronous soft reset from slave; same effect as hrst
//  glb_ctrl   in   32  [0] start (rising edge), [1] continuous, [2] abort (level)
//  cfg_par0   in   32  [XW-1:0] width W, [16+YW-1:16] height H
//  cfg_par1   in   32  [GW-1:0] line gap G (idle cycles after each line)
//  pix_rdy    in   1   downstream ready
//  pix_vld    out  1   coordinate valid
//  pix_x      out  XW  column, 0..W-1
//  pix_y      out  YW  row, 0..H-1
//  pix_sof    out  1   first beat of frame (x=0,y=0)
//  pix_eol    out  1   last beat of line (x=W-1)
//  pix_eof    out  1   last beat of frame (x=W-1,y=H-1)
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse: sequence ended normally
//  cfg_err    out  1   one-cycle pulse: start with W==0 or H==0
//  frm_cnt    out  FW  completed frames since reset, wraps at 2^FW
//  stall_cnt  out  32  see CONFIGURATION
// BEHAVIOUR
//  - Reset (hrst or sw_rst): state IDLE; every output 0; start-edge register 0.
//  - start_p = glb_ctrl[0] & ~glb_ctrl0_q. Edges are ignored unless in IDLE.
//  - States: IDLE, LOAD, RUN, GAP, DONE.
//  - IDLE -> LOAD on start_p.
//  - LOAD: latch W, H, G into shadow regs; x=y=0.
//    If W==0 or H==0: pulse cfg_err and go to IDLE.
//    Otherwise go to RUN. First pix_vld is asserted 2 cycles after the start edge.
//  - RUN: pix_vld=1. A beat transfers when pix_vld&pix_rdy.
//    pix_x/pix_y/flags are stable while pix_vld&~pix_rdy.
//  - Beat accepted with x<W-1: x++.
//  - Beat accepted with x==W-1, y<H-1: x=0, y++.
//    Go to GAP if G!=0, else stay in RUN. Back-to-back lines have no bubble.
//  - GAP: pix_vld=0. Count G cycles, then return to RUN.
//  - Beat accepted on eof: frm_cnt++.
//    If glb_ctrl[1]=1: go to LOAD (re-latches config; frames chain).
//    Otherwise go to DONE.
//  - DONE: done=1 for one cycle, then IDLE.
//  - Abort (glb_ctrl[2]=1) in RUN/GAP takes effect only when ~pix_vld | pix_rdy,
//    so an offered beat is never withdrawn. It then goes straight to IDLE:
//    no done pulse, no frm_cnt increment. An accepted eof beat on the abort
//    cycle still counts.
//  - Abort in LOAD goes to IDLE. Abort held in IDLE blocks start.
//  - cfg_par changes during a frame have no effect until the next LOAD.
//  - pix_sof/eol/eof are combinational from x, y and the shadow regs, gated by
//    pix_vld. W==1 gives eol on every beat. W==H==1 gives sof&eol&eof on one beat.
//  - sw_rst mid-frame: next cycle all outputs 0, pix_vld=0.
//    The protocol exception is accepted.
// CONFIGURATION
//  IVS_SCAN_STALL_CNT_EN
//    defined: stall_cnt increments each cycle pix_vld&~pix_rdy; saturates at
//             32'hFFFF_FFFF; clears on LOAD and on reset.
//    undefined: stall_cnt is tied to 0; no counter flops.
// TESTING
//  1. W=4,H=2,G=0,cont=0, rdy=1, start edge -> vld 2 cycles later; 8 beats
//     x=0..3,y=0..1; sof on beat 0; eol on beats 3,7; eof on 7;
//     done 1 cycle later; frm_cnt=1.
//  2. W=3,H=2,G=5, rdy toggling 1/0 -> coords/flags held while stalled;
//     exactly 5 idle cycles between beat 2 and beat 3; stall_cnt equals
//     stalled cycles (with the macro defined).
//  3. W=0,H=4 start -> cfg_err one pulse 1 cycle after LOAD; no vld; busy
//     drops; frm_cnt unchanged.
//  4. cont=1, W=2,H=1 -> frames chain with a 1-cycle LOAD bubble; clear cont
//     mid-frame -> current frame completes, done, frm_cnt=N.
//  5. Abort asserted while vld=1,rdy=0 -> vld held until rdy; then IDLE,
//     no done, no count.
//  6. sw_rst pulse mid-RUN -> next cycle busy=0, vld=0, frm_cnt=0;
//     new start edge restarts at x=y=0.

Source files
------------

// File: rtl/ivs_scan_ctrl_if.sv
// Bundle between the IVS AHB slave, the scan sequencer and the pixel datapath.
// master: the sequencer view (consumes control/config, drives the coordinate stream and status).
// slave:  the environment view (drives control/config and ready, observes the stream).
interface ivs_scan_ctrl_if #(
    parameter int unsigned XW = 12,
    parameter int unsigned YW = 12,
    parameter int unsigned FW = 16
);
    logic          sw_rst;
    logic [31:0]   glb_ctrl;
    logic [31:0]   cfg_par0;
    logic [31:0]   cfg_par1;
    logic          pix_rdy;
    logic          pix_vld;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [FW-1:0] frm_cnt;
    logic [31:0]   stall_cnt;

    modport master (
        input  sw_rst, glb_ctrl, cfg_par0, cfg_par1, pix_rdy,
        output pix_vld, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        output busy, done, cfg_err, frm_cnt, stall_cnt
    );

    modport slave (
        output sw_rst, glb_ctrl, cfg_par0, cfg_par1, pix_rdy,
        input  pix_vld, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        input  busy, done, cfg_err, frm_cnt, stall_cnt
    );
endinterface

// File: rtl/ivs_scan_ctrl.sv
// Frame scan sequencer: walks a W x H raster on a valid/ready stream with an optional
// idle gap after each line, and reports busy/done/cfg_err plus a completed-frame count.
// Optional feature: define IVS_SCAN_STALL_CNT_EN to build the saturating stall counter;
// otherwise stall_cnt is tied to zero.
// The interface instance must use the same XW/YW/FW as this module.
module ivs_scan_ctrl #(
    parameter int unsigned XW = 12,
    parameter int unsigned YW = 12,
    parameter int unsigned GW = 16,
    parameter int unsigned FW = 16
) (
    input logic               hclk,
    input logic               hrst,
    ivs_scan_ctrl_if.master   bus
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StGap, StDone} state_e;

    state_e        state_q, state_d;
    logic          glb0_q;
    logic [XW-1:0] w_q, w_d, x_q, x_d;
    logic [YW-1:0] h_q, h_d, y_q, y_d;
    logic [GW-1:0] g_q, g_d, gap_q, gap_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          err_q, err_d;

    logic          start_p, cont, abort, vld, last_x, last_y;
    logic [XW-1:0] cfg_w;
    logic [YW-1:0] cfg_h;
    logic [GW-1:0] cfg_g;

    assign start_p = bus.glb_ctrl[0] & ~glb0_q;
    assign cont    = bus.glb_ctrl[1];
    assign abort   = bus.glb_ctrl[2];
    assign cfg_w   = bus.cfg_par0[XW-1:0];
    assign cfg_h   = bus.cfg_par0[16+YW-1:16];
    assign cfg_g   = bus.cfg_par1[GW-1:0];

    logic unused_bits;
    assign unused_bits = ^{bus.glb_ctrl[31:3], bus.cfg_par0[31:16+YW], bus.cfg_par0[15:XW],
                           bus.cfg_par1[31:GW]};

    assign vld    = (state_q == StRun);
    assign last_x = (x_q == w_q - XW'(1));
    assign last_y = (y_q == h_q - YW'(1));

    // State, shadow config, coordinates and counters; sw_rst acts like hrst one edge later.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q <= StIdle;
            glb0_q  <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            g_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            gap_q   <= '0;
            frm_q   <= '0;
            err_q   <= 1'b0;
        end else if (bus.sw_rst) begin
            state_q <= StIdle;
            glb0_q  <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            g_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            gap_q   <= '0;
            frm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            glb0_q  <= bus.glb_ctrl[0];
            w_q     <= w_d;
            h_q     <= h_d;
            g_q     <= g_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gap_q   <= gap_d;
            frm_q   <= frm_d;
            err_q   <= err_d;
        end
    end

    // Next-state: raster walk, line gap, frame chaining and abort handling.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        g_d     = g_q;
        x_d     = x_q;
        y_d     = y_q;
        gap_d   = gap_q;
        frm_d   = frm_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_p && !abort) state_d = StLoad;
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    w_d = cfg_w;
                    h_d = cfg_h;
                    g_d = cfg_g;
                    x_d = '0;
                    y_d = '0;
                    if (cfg_w == '0 || cfg_h == '0) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // vld is high here, so abort waits for the offered beat to be taken.
                if (bus.pix_rdy) begin
                    if (!last_x) begin
                        x_d = x_q + XW'(1);
                    end else if (!last_y) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                        if (g_q != '0) begin
                            gap_d   = '0;
                            state_d = StGap;
                        end
                    end else begin
                        frm_d   = frm_q + FW'(1);
                        state_d = cont ? StLoad : StDone;
                    end
                    if (abort) state_d = StIdle;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_q == g_q - GW'(1)) begin
                    state_d = StRun;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.pix_vld = vld;
    assign bus.pix_x   = x_q;
    assign bus.pix_y   = y_q;
    assign bus.pix_sof = vld & (x_q == '0) & (y_q == '0);
    assign bus.pix_eol = vld & last_x;
    assign bus.pix_eof = vld & last_x & last_y;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.cfg_err = err_q;
    assign bus.frm_cnt = frm_q;

`ifdef IVS_SCAN_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a beat is offered but not taken; cleared per LOAD.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            stall_q <= '0;
        end else if (bus.sw_rst || state_q == StLoad) begin
            stall_q <= '0;
        end else if (vld && !bus.pix_rdy && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule
